// File: rtl/acs_pkg.sv
// Shared constants, types and trellis helper for the 4-state add-compare-select unit.
package acs_pkg;
  localparam int NUM_STATES = 4;
  localparam int METRIC_W   = 4;
  localparam int PATH_W     = 8;
  localparam int PTR_W      = 3;

  typedef logic [METRIC_W-1:0] metric_t;
  typedef logic [PATH_W-1:0]   path_t;
  typedef logic [PTR_W-1:0]    ptr_t;

  localparam metric_t METRIC_MAX = 4'd15;

  // Predecessor k (0/1) of state n: the shift register's oldest bit was k.
  function automatic logic [1:0] pred(input logic [1:0] n, input logic k);
    return {n[0], k};
  endfunction
endpackage

// File: rtl/acs_if.sv
// Step bus between branch-metric unit, ACS and traceback stage.
interface acs_if;
  import acs_pkg::*;
  metric_t branch_metric_00_0, branch_metric_00_1, branch_metric_01_0, branch_metric_01_1;
  metric_t branch_metric_10_0, branch_metric_10_1, branch_metric_11_0, branch_metric_11_1;
  path_t   selected_branch_at_00, selected_branch_at_01;
  path_t   selected_branch_at_10, selected_branch_at_11;
  ptr_t    write_pointer_in;
  logic    valid_in;
  metric_t new_branch_metric_00, new_branch_metric_01, new_branch_metric_10, new_branch_metric_11;
  path_t   updated_selected_branch_at_00, updated_selected_branch_at_01;
  path_t   updated_selected_branch_at_10, updated_selected_branch_at_11;
  ptr_t    write_pointer_out;
  logic    valid_out;

  modport master (
    output branch_metric_00_0, branch_metric_00_1, branch_metric_01_0, branch_metric_01_1,
           branch_metric_10_0, branch_metric_10_1, branch_metric_11_0, branch_metric_11_1,
           selected_branch_at_00, selected_branch_at_01, selected_branch_at_10,
           selected_branch_at_11, write_pointer_in, valid_in,
    input  new_branch_metric_00, new_branch_metric_01, new_branch_metric_10, new_branch_metric_11,
           updated_selected_branch_at_00, updated_selected_branch_at_01,
           updated_selected_branch_at_10, updated_selected_branch_at_11,
           write_pointer_out, valid_out
  );

  modport slave (
    input  branch_metric_00_0, branch_metric_00_1, branch_metric_01_0, branch_metric_01_1,
           branch_metric_10_0, branch_metric_10_1, branch_metric_11_0, branch_metric_11_1,
           selected_branch_at_00, selected_branch_at_01, selected_branch_at_10,
           selected_branch_at_11, write_pointer_in, valid_in,
    output new_branch_metric_00, new_branch_metric_01, new_branch_metric_10, new_branch_metric_11,
           updated_selected_branch_at_00, updated_selected_branch_at_01,
           updated_selected_branch_at_10, updated_selected_branch_at_11,
           write_pointer_out, valid_out
  );
endinterface

// File: rtl/acs_cell.sv
// Combinational add-compare-select for one destination state N.
module acs_cell
  import acs_pkg::*;
#(
  parameter int N = 0
) (
  input  metric_t             pm0,
  input  metric_t             pm1,
  input  metric_t             bm0,
  input  metric_t             bm1,
  output logic [METRIC_W:0]   sel,
  output logic                win,
  output logic                dec
);
  localparam logic [1:0] NS = 2'(N);

  logic [METRIC_W:0] c0, c1;

  assign c0  = {1'b0, pm0} + {1'b0, bm0};
  assign c1  = {1'b0, pm1} + {1'b0, bm1};
  // Ties resolve toward predecessor 0.
  assign win = (c1 < c0);
  assign sel = win ? c1 : c0;
  assign dec = NS[1];
endmodule

// File: rtl/acs.sv
// 4-state ACS step: per-state select, min-normalize with saturation, survivor bit insertion.
module acs
  import acs_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  acs_if.slave  bus
);
  metric_t [NUM_STATES-1:0][1:0] bm;
  path_t   [NUM_STATES-1:0]      sp;

  assign bm = {bus.branch_metric_11_1, bus.branch_metric_11_0,
               bus.branch_metric_10_1, bus.branch_metric_10_0,
               bus.branch_metric_01_1, bus.branch_metric_01_0,
               bus.branch_metric_00_1, bus.branch_metric_00_0};
  assign sp = {bus.selected_branch_at_11, bus.selected_branch_at_10,
               bus.selected_branch_at_01, bus.selected_branch_at_00};

  metric_t [NUM_STATES-1:0]             pm_q, pm_d;
  path_t   [NUM_STATES-1:0]             path_q, path_d;
  ptr_t                                 ptr_q;
  logic                                 vld_q;
  logic    [NUM_STATES-1:0][METRIC_W:0] sel, diff;
  logic    [NUM_STATES-1:0]             win, dec;
  logic    [METRIC_W:0]                 m01, m23, mn;

  for (genvar n = 0; n < NUM_STATES; n++) begin : g_cell
    localparam logic [1:0] P0 = pred(2'(n), 1'b0);
    localparam logic [1:0] P1 = pred(2'(n), 1'b1);
    localparam logic       U  = 1'(n >> 1);
    acs_cell #(.N(n)) u_cell (
      .pm0 (pm_q[P0]),
      .pm1 (pm_q[P1]),
      .bm0 (bm[P0][U]),
      .bm1 (bm[P1][U]),
      .sel (sel[n]),
      .win (win[n]),
      .dec (dec[n])
    );
  end

  // Subtracting the minimum keeps the best path at 0; saturation caps hopeless paths.
  always_comb begin
    m01  = (sel[0] < sel[1]) ? sel[0] : sel[1];
    m23  = (sel[2] < sel[3]) ? sel[2] : sel[3];
    mn   = (m01 < m23) ? m01 : m23;
    diff = '0;
    pm_d = '0;
    for (int n = 0; n < NUM_STATES; n++) begin
      diff[n] = sel[n] - mn;
      pm_d[n] = (diff[n] > {1'b0, METRIC_MAX}) ? METRIC_MAX : diff[n][METRIC_W-1:0];
    end
  end

  always_comb begin
    path_d = '0;
    for (int n = 0; n < NUM_STATES; n++) begin
      path_d[n]                       = sp[pred(2'(n), win[n])];
      path_d[n][bus.write_pointer_in] = dec[n];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm_q   <= {METRIC_MAX, METRIC_MAX, METRIC_MAX, metric_t'(0)};
      path_q <= '0;
      ptr_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= bus.valid_in;
      if (bus.valid_in) begin
        pm_q   <= pm_d;
        path_q <= path_d;
        ptr_q  <= bus.write_pointer_in + ptr_t'(1);
      end
    end
  end

  assign bus.new_branch_metric_00          = pm_q[0];
  assign bus.new_branch_metric_01          = pm_q[1];
  assign bus.new_branch_metric_10          = pm_q[2];
  assign bus.new_branch_metric_11          = pm_q[3];
  assign bus.updated_selected_branch_at_00 = path_q[0];
  assign bus.updated_selected_branch_at_01 = path_q[1];
  assign bus.updated_selected_branch_at_10 = path_q[2];
  assign bus.updated_selected_branch_at_11 = path_q[3];
  assign bus.write_pointer_out             = ptr_q;
  assign bus.valid_out                     = vld_q;
endmodule

// File: tb/tb_acs.sv
// Directed + random bench for acs against a forward-expanding trellis model.
module tb_acs;
  logic clk = 1'b0;
  logic rst = 1'b0;
  acs_if bus ();

  acs dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // stimulus
  int       bm_g [4][2];
  logic [7:0] sp_g [4];
  int       ptr_g;

  // reference state
  int       mpm [4];
  logic [7:0] mpath [4];
  int       mptr;
  logic     mvld;

  logic [3:0][3:0] obs_pm;
  logic [3:0][7:0] obs_path;
  assign obs_pm   = {bus.new_branch_metric_11, bus.new_branch_metric_10,
                     bus.new_branch_metric_01, bus.new_branch_metric_00};
  assign obs_path = {bus.updated_selected_branch_at_11, bus.updated_selected_branch_at_10,
                     bus.updated_selected_branch_at_01, bus.updated_selected_branch_at_00};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mpm = '{0, 15, 15, 15};
    for (int n = 0; n < 4; n++) mpath[n] = 8'h00;
    mptr = 0;
    mvld = 1'b0;
  endtask

  // Expand every transition forward; a strictly better candidate replaces the
  // stored one, so visiting lower source states first keeps p0 on ties.
  task automatic model_step(input logic v);
    int best [4];
    int src [4];
    int mn;
    logic [7:0] p;
    mvld = v;
    if (!v) return;
    for (int n = 0; n < 4; n++) best[n] = -1;
    for (int s = 0; s < 4; s++)
      for (int u = 0; u < 2; u++) begin
        int ns = u * 2 + s / 2;
        int c  = mpm[s] + bm_g[s][u];
        if (best[ns] < 0 || c < best[ns]) begin
          best[ns] = c;
          src[ns]  = s;
        end
      end
    mn = best[0];
    for (int n = 1; n < 4; n++) if (best[n] < mn) mn = best[n];
    for (int n = 0; n < 4; n++) begin
      mpm[n] = (best[n] - mn > 15) ? 15 : best[n] - mn;
      p = sp_g[src[n]];
      p[ptr_g] = (n >= 2);
      mpath[n] = p;
    end
    mptr = (ptr_g + 1) % 8;
  endtask

  task automatic drive(input logic v);
    bus.branch_metric_00_0 = 4'(bm_g[0][0]); bus.branch_metric_00_1 = 4'(bm_g[0][1]);
    bus.branch_metric_01_0 = 4'(bm_g[1][0]); bus.branch_metric_01_1 = 4'(bm_g[1][1]);
    bus.branch_metric_10_0 = 4'(bm_g[2][0]); bus.branch_metric_10_1 = 4'(bm_g[2][1]);
    bus.branch_metric_11_0 = 4'(bm_g[3][0]); bus.branch_metric_11_1 = 4'(bm_g[3][1]);
    bus.selected_branch_at_00 = sp_g[0];
    bus.selected_branch_at_01 = sp_g[1];
    bus.selected_branch_at_10 = sp_g[2];
    bus.selected_branch_at_11 = sp_g[3];
    bus.write_pointer_in = 3'(ptr_g);
    bus.valid_in = v;
  endtask

  task automatic check_all(input string tag);
    int mn = 15;
    for (int n = 0; n < 4; n++) begin
      check($sformatf("%s_pm%0d", tag, n), 32'(obs_pm[n]), 32'(mpm[n]));
      check($sformatf("%s_path%0d", tag, n), 32'(obs_path[n]), 32'(mpath[n]));
      if (int'(obs_pm[n]) < mn) mn = int'(obs_pm[n]);
    end
    check({tag, "_ptr"}, 32'(bus.write_pointer_out), 32'(mptr));
    check({tag, "_vld"}, 32'(bus.valid_out), 32'(mvld));
    check({tag, "_minzero"}, 32'(mn), 32'd0);
  endtask

  task automatic step(input logic v, input string tag);
    drive(v);
    @(posedge clk);
    model_step(v);
    #1;
    check_all(tag);
  endtask

  task automatic rand_inputs();
    for (int s = 0; s < 4; s++) begin
      bm_g[s][0] = $urandom_range(0, 15);
      bm_g[s][1] = $urandom_range(0, 15);
      sp_g[s]    = 8'($urandom);
    end
    ptr_g = $urandom_range(0, 7);
  endtask

  task automatic load_ref_case();
    bm_g  = '{'{1, 2}, '{3, 4}, '{2, 1}, '{4, 3}};
    sp_g  = '{8'b10100000, 8'b11000000, 8'b11100000, 8'b00000000};
    ptr_g = 3;
  endtask

  task automatic check_ref_case(input string tag);
    check({tag, "_pm"},   32'(obs_pm),   32'({4'd15, 4'd1, 4'd15, 4'd0}));
    check({tag, "_path"}, 32'(obs_path),
          32'({8'b11101000, 8'b10101000, 8'b11100000, 8'b10100000}));
    check({tag, "_ptr"},  32'(bus.write_pointer_out), 32'd4);
    check({tag, "_vld"},  32'(bus.valid_out), 32'd1);
  endtask

  initial begin
    model_reset();
    rand_inputs();
    drive(1'b1);
    #12;
    check_all("reset");
    check("reset_pm_const", 32'(obs_pm), 32'({4'd15, 4'd15, 4'd15, 4'd0}));

    // release away from the clock edge
    @(negedge clk);
    rst = 1'b1;
    load_ref_case();
    step(1'b1, "ref");
    check_ref_case("ref_c");
    step(1'b0, "ref_drop");

    // tie: from reset metrics, zero branch metrics tie into 01 and 11
    rst = 1'b0; model_reset(); #1; rst = 1'b1;
    bm_g  = '{'{0, 0}, '{0, 0}, '{0, 0}, '{0, 0}};
    sp_g  = '{8'h11, 8'h22, 8'h33, 8'h44};
    ptr_g = 2;
    step(1'b1, "tie");
    check("tie_01", 32'(obs_path[1]), 32'h33);
    check("tie_11", 32'(obs_path[3]), 32'h37);

    // pointer wrap
    rand_inputs(); ptr_g = 7;
    step(1'b1, "wrap7");
    check("wrap7_ptr", 32'(bus.write_pointer_out), 32'd0);
    check("wrap7_bit", 32'({obs_path[3][7], obs_path[2][7], obs_path[1][7], obs_path[0][7]}),
          32'b1100);
    rand_inputs(); ptr_g = 6;
    step(1'b1, "wrap6");
    check("wrap6_ptr", 32'(bus.write_pointer_out), 32'd7);

    // saturation / normalization with survivor feedback
    bm_g = '{'{0, 15}, '{15, 0}, '{0, 15}, '{15, 0}};
    for (int i = 0; i < 6; i++) begin
      sp_g  = mpath;
      ptr_g = mptr;
      step(1'b1, "sat");
    end

    // idle cycles: inputs churn, outputs hold
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      step(1'b0, "idle");
    end

    // random traffic
    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      if ($urandom_range(0, 1) == 0) begin
        sp_g  = mpath;
        ptr_g = mptr;
      end
      step($urandom_range(0, 3) != 0, "rand");
    end

    // reset mid-stream with a valid step in flight
    rand_inputs();
    drive(1'b1);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("midrst");
    @(posedge clk); #1;
    check_all("midrst_hold");
    rst = 1'b1;
    load_ref_case();
    step(1'b1, "ref2");
    check_ref_case("ref2_c");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/acs.md
# acs

Add-compare-select unit for a 4-state (constraint length 3, rate 1/2) register-exchange Viterbi decoder. Each valid cycle it adds per-transition branch metrics to its stored path metrics and selects the survivor into every state. It writes the decision bit into that survivor's path history and advances the history write pointer. It sits between the branch-metric unit and the traceback/output stage.

## Interface
- No parameters: metric width 4, path width 8, pointer width 3, 4 states (fixed constants).
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- branch_metric_SS_B  input  4  metric of the transition leaving state SS (00/01/10/11) with input bit B (0/1); 8 ports.
- selected_branch_at_SS  input  8  current path history of state SS; 4 ports.
- write_pointer_in  input  3  bit index to write this step.
- valid_in  input  1  step qualifier.
- new_branch_metric_SS  output  4  registered normalized path metric of state SS; 4 ports.
- updated_selected_branch_at_SS  output  8  registered survivor history of state SS; 4 ports.
- write_pointer_out  output  3  registered next write index.
- valid_out  output  1  registered step-done strobe.

## Operation
- Trellis: state s = {s1,s0}; input bit u moves s to {u,s1}. Predecessors of n = {n1,n0} are p0 = {n0,0} and p1 = {n0,1}; entry bit is u = n1.
- Path metrics are the new_branch_metric_* registers themselves (PM).
- Add: for each n, c0 = PM[p0] + branch_metric_p0_u and c1 = PM[p1] + branch_metric_p1_u, both 5-bit unsigned.
- Compare/select: winner = p1 only if c1 < c0; a tie selects p0.
- Normalize: m = min of the four selected 5-bit metrics. PM_next[n] = selected − m, saturated to 15 and stored as 4 bits. After any step, at least one state has metric 0.
- Path: updated_selected_branch_at_n = selected_branch_at_winner with bit [write_pointer_in] replaced by u. All other bits are copied unchanged.
- write_pointer_out = write_pointer_in + 1 mod 8, so 7 wraps to 0.
- valid_in = 0: PM, path outputs and write_pointer_out hold; valid_out = 0.

## Timing
- Latency 1 cycle: inputs sampled at edge k when valid_in = 1; results visible after edge k; valid_out high for exactly that cycle.
- Back-to-back valid steps are accepted every cycle; the feedback PM → add → compare → normalize path must close in one cycle.
- Reset values, applied immediately (asynchronous): new_branch_metric_00 = 0; new_branch_metric_01/10/11 = 15; all updated paths = 0; write_pointer_out = 0; valid_out = 0.
- Reset mid-operation discards the in-flight step. The first valid step after release uses the reset metrics.
- Inputs carry no handshake beyond valid_in; there is no backpressure.

## Structure
- Shared package acs_pkg holds:
  - constants NUM_STATES = 4, METRIC_W = 4, PATH_W = 8, PTR_W = 3, METRIC_MAX = 15;
  - typedefs metric_t, path_t, ptr_t;
  - function pred(n, k) returning {n[0], k}.
- One natural sub-module, acs_cell, instantiated 4×. It is purely combinational:
  - adds both candidates;
  - compares with the tie rule;
  - outputs the 5-bit selected metric, the winner index and the decision bit.
- Top level does the normalization min-tree, path bit insertion and all registers.

## Test plan
- Reset: hold rst = 0 → outputs {0,15,15,15}, all paths 0, write_pointer_out = 0, valid_out = 0.
- Step from reset:
  - stimulus: metrics 00_0..11_1 = 1,2,3,4,2,1,4,3; paths 10100000, 11000000, 11100000, 00000000; ptr 3;
  - required: metrics {0,15,1,15}; paths 10100000, 11100000, 10101000, 11101000; ptr_out 4; valid_out pulse.
- Tie: equal candidates into a state → p0 history selected, decision bit = n1.
- Pointer wrap: ptr 7 → write_pointer_out 0, bit 7 written; ptr 6 → 7.
- Saturation and normalization:
  - stimulus: metrics 0,15,15,0,0,15,15,0 on repeated steps;
  - required: no metric exceeds 15, min metric always 0, no 4-bit wrap.
- valid_in = 0 for several cycles → outputs hold and valid_out = 0. Reset pulse mid-stream → reset values immediately; the next valid step matches the step-from-reset case.
